rf_ctrl: RTL and testbench
==========================

# rf_ctrl

Command-driven access controller: the initiator side of the 8×16 register file. It accepts read/write/copy/clear commands over a valid/ready handshake and drives the register file's write port and two asynchronous read ports. It returns read results over a second valid/ready handshake. It sits between the lab's debug/test front end (or a future control unit) and the register file.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NREG, 8, number of registers walked by CLEAR (2**ADDR_W)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 READ, 01 WRITE, 10 COPY, 11 CLEAR
- cmd_addr_a  in  ADDR_W  READ: rd0 address; WRITE: destination; COPY: source
- cmd_addr_b  in  ADDR_W  READ: rd1 address; COPY: destination
- cmd_data  in  DATA_W  WRITE data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data0, rsp_data1  out  DATA_W  response payload
- rf_wr_en  out  1  write enable to register file
- rf_wr_addr  out  ADDR_W  write address
- rf_wr_data  out  DATA_W  write data
- rf_rd0_addr, rf_rd1_addr  out  ADDR_W  read addresses
- rf_rd0_data, rf_rd1_data  in  DATA_W  combinational read data from register file
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, CLEAR, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, addresses and data, then go to CLEAR if op==CLEAR, else EXEC.
- EXEC (exactly one cycle):
  - READ: rf_rd0_addr=a, rf_rd1_addr=b. Capture rf_rd0_data/rf_rd1_data into rsp_data0/1, then go to RESP.
  - WRITE: rf_wr_en=1, wr_addr=a, wr_data=latched data. Then go to IDLE.
  - COPY: rf_rd0_addr=a, rf_wr_en=1, wr_addr=b, wr_data=rf_rd0_data (same cycle). Then go to IDLE. a==b is legal and rewrites the same value.
- CLEAR:
  - An ADDR_W-bit counter starts at 0. Each cycle writes 0 to register[counter] with rf_wr_en=1.
  - After address NREG-1, go to IDLE. Takes exactly NREG cycles; the counter does not wrap.
- RESP:
  - rsp_valid=1 and rsp_data held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
- Outside EXEC-write/COPY and CLEAR, rf_wr_en=0. rf_* addresses and data are 0 when not in use.
- cmd_ready is low in EXEC, CLEAR and RESP. New commands stall while a response is pending.

## Timing
- Reset (rst=0), effective immediately:
  - state=IDLE; cmd_ready=0 while rst=0, 1 from the first cycle after release.
  - rsp_valid=0, rsp_data0/1=0.
  - rf_wr_en=0, all rf_* addresses and data=0.
  - busy=0, CLEAR counter=0.
- Reset mid-CLEAR aborts the walk. Registers already cleared stay cleared; no further writes occur.
- rf_* outputs decode combinationally from state and latched command; no output register on the register-file side.
- READ: accept at edge N, EXEC in cycle N+1, rsp_valid high from cycle N+2.
- WRITE/COPY: accept at edge N, rf_wr_en high in cycle N+1, register updated at edge N+2, cmd_ready high again in cycle N+2.
- CLEAR: accept at edge N, writes in cycles N+1..N+NREG, cmd_ready high in cycle N+NREG+1.
- Peak throughput: one WRITE/COPY every 2 cycles.

## Configuration
- RF_CTRL_WRITE_ACK_EN defined:
  - WRITE and COPY also go to RESP after EXEC: rsp_data0 = written value, rsp_data1 = 0.
  - CLEAR goes to RESP after its last write with rsp_data0/1 = 0.
- RF_CTRL_WRITE_ACK_EN undefined: only READ produces a response; WRITE, COPY and CLEAR return directly to IDLE.

## Structure
- Package rf_ctrl_pkg holds:
  - rf_op_t enum (READ, WRITE, COPY, CLEAR);
  - rf_ctrl_state_t enum (IDLE, EXEC, CLEAR, RESP);
  - default DATA_W/ADDR_W/NREG constants.
- No sub-module: the FSM, CLEAR counter and response registers are a single module.

## Test plan
- Reset, then WRITE a=3, data=16'hBEEF; then READ a=3, b=0 -> rsp_data0=16'hBEEF, rsp_data1=0, rsp_valid exactly 2 cycles after READ accept.
- WRITE r1=16'h1234, then COPY a=1, b=6, then READ a=6, b=1 -> both responses 16'h1234; rf_wr_en high for exactly 1 cycle per write.
- Write all 8 registers with nonzero values, then CLEAR -> rf_wr_en high 8 consecutive cycles with addresses 0..7, all reads return 0, cmd_ready low for 8 cycles.
- READ with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable throughout; a cmd_valid offered meanwhile is not accepted until after the handshake.
- Assert rst mid-CLEAR (after address 3) -> rf_wr_en drops immediately; r0..r3=0, r4..r7 retain values; cmd_ready=1 after release.
- With RF_CTRL_WRITE_ACK_EN: WRITE a=2, data=16'h00FF -> rsp_valid with rsp_data0=16'h00FF; without the macro, no rsp_valid.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and default sizes for the register-file access controller.
// Optional behaviour is selected in rf_ctrl by the RF_CTRL_WRITE_ACK_EN macro.
package rf_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NREG   = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,
        OP_CLEAR = 2'b11
    } rf_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_CLEAR = 2'b10,
        ST_RESP  = 2'b11
    } rf_ctrl_state_t;

endpackage

// File: rtl/rf_ctrl.sv
// Command-driven initiator for the 8x16 register file: READ/WRITE/COPY/CLEAR over valid/ready.
// Define RF_CTRL_WRITE_ACK_EN to make WRITE, COPY and CLEAR also return a response.
import rf_ctrl_pkg::*;

module rf_ctrl #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = DEF_NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data0,
    output logic [DATA_W-1:0] rsp_data1,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [ADDR_W-1:0] rf_rd0_addr,
    output logic [ADDR_W-1:0] rf_rd1_addr,
    input  logic [DATA_W-1:0] rf_rd0_data,
    input  logic [DATA_W-1:0] rf_rd1_data,
    output logic              busy
);

    rf_ctrl_state_t    r_state;
    rf_ctrl_state_t    w_state_nxt;
    rf_op_t            r_op;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_rsp_data0;
    logic [DATA_W-1:0] r_rsp_data1;
    logic              w_accept;
    logic              w_clr_last;

    // cmd_ready is gated by rst so it stays low for the whole reset pulse
    assign cmd_ready  = rst & (r_state == ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE);
    assign rsp_data0  = r_rsp_data0;
    assign rsp_data1  = r_rsp_data1;
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_clr_last = (r_clr_cnt == ADDR_W'(NREG - 1));

    // Register-file port decode from state and latched command
    always_comb begin
        rf_wr_en    = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        rf_rd0_addr = '0;
        rf_rd1_addr = '0;
        case (r_state)
            ST_EXEC: begin
                case (r_op)
                    OP_READ: begin
                        rf_rd0_addr = r_addr_a;
                        rf_rd1_addr = r_addr_b;
                    end
                    OP_WRITE: begin
                        rf_wr_en   = 1'b1;
                        rf_wr_addr = r_addr_a;
                        rf_wr_data = r_data;
                    end
                    OP_COPY: begin
                        rf_rd0_addr = r_addr_a;
                        rf_wr_en    = 1'b1;
                        rf_wr_addr  = r_addr_b;
                        rf_wr_data  = rf_rd0_data;
                    end
                    default: begin
                        rf_wr_en = 1'b0;
                    end
                endcase
            end
            ST_CLEAR: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = r_clr_cnt;
            end
            default: begin
                rf_wr_en = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (rf_op_t'(cmd_op) == OP_CLEAR) ? ST_CLEAR : ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
`ifdef RF_CTRL_WRITE_ACK_EN
                w_state_nxt = ST_RESP;
`else
                w_state_nxt = (r_op == OP_READ) ? ST_RESP : ST_IDLE;
`endif
            end
            ST_CLEAR: begin
                if (w_clr_last) begin
`ifdef RF_CTRL_WRITE_ACK_EN
                    w_state_nxt = ST_RESP;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, command latch and CLEAR walk counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_READ;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_data    <= '0;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op     <= rf_op_t'(cmd_op);
                r_addr_a <= cmd_addr_a;
                r_addr_b <= cmd_addr_b;
                r_data   <= cmd_data;
            end
            // counter is parked at 0 explicitly after the last address rather than wrapping
            if ((r_state == ST_CLEAR) && !w_clr_last) begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end else begin
                r_clr_cnt <= '0;
            end
        end
    end

    // Response payload capture; held unchanged while waiting in RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_data0 <= '0;
            r_rsp_data1 <= '0;
        end else if ((r_state == ST_EXEC) && (r_op == OP_READ)) begin
            r_rsp_data0 <= rf_rd0_data;
            r_rsp_data1 <= rf_rd1_data;
`ifdef RF_CTRL_WRITE_ACK_EN
        end else if ((r_state == ST_EXEC) && ((r_op == OP_WRITE) || (r_op == OP_COPY))) begin
            r_rsp_data0 <= rf_wr_data;
            r_rsp_data1 <= '0;
        end else if ((r_state == ST_CLEAR) && w_clr_last) begin
            r_rsp_data0 <= '0;
            r_rsp_data1 <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_rf_ctrl.sv
// Self-checking bench for rf_ctrl: directed vector table, corner sequences and random commands
// checked against an array-level model of the register file contents.
module tb_rf_ctrl;

    localparam logic [1:0] OPR = 2'b00;
    localparam logic [1:0] OPW = 2'b01;
    localparam logic [1:0] OPC = 2'b10;
    localparam logic [1:0] OPX = 2'b11;

`ifdef RF_CTRL_WRITE_ACK_EN
    localparam bit ACK_MODE = 1'b1;
`else
    localparam bit ACK_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [2:0]  cmd_addr_a = 3'd0;
    logic [2:0]  cmd_addr_b = 3'd0;
    logic [15:0] cmd_data = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data0, rsp_data1;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr, rf_rd0_addr, rf_rd1_addr;
    logic [15:0] rf_wr_data, rf_rd0_data, rf_rd1_data;
    logic        busy;

    logic [15:0] rf_mem [8];
    logic [15:0] ref_regs [8];
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] d;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;
    vec_t vt [9];

    rf_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
        .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural register file the controller drives
    always @(posedge clk) begin
        if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
    end
    assign rf_rd0_data = rf_mem[rf_rd0_addr];
    assign rf_rd1_data = rf_mem[rf_rd1_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one command with rsp_ready high, checking cycle-by-cycle timing and the model
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [15:0] d, input logic [15:0] re0, input logic [15:0] re1);
        int waitc;
        logic [15:0] wval;
        logic [15:0] e0, e1;
        bit has;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
        waitc = 0;
        while (!cmd_ready && waitc < 30) begin
            @(negedge clk);
            waitc++;
        end
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wval = (op == OPW) ? d : ref_regs[a];
        case (op)
            OPR: begin
                chk("read_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                chk("read_exec_wr_en", {31'd0, rf_wr_en}, 32'd0);
                chk("read_rd0_addr", {29'd0, rf_rd0_addr}, {29'd0, a});
                chk("read_rd1_addr", {29'd0, rf_rd1_addr}, {29'd0, b});
                @(negedge clk);
            end
            OPW, OPC: begin
                chk("wr_en_cycle1", {31'd0, rf_wr_en}, 32'd1);
                chk("wr_addr", {29'd0, rf_wr_addr}, {29'd0, (op == OPW) ? a : b});
                chk("wr_data", {16'd0, rf_wr_data}, {16'd0, wval});
                chk("wr_busy", {31'd0, busy}, 32'd1);
                @(negedge clk);
                chk("wr_en_cycle2", {31'd0, rf_wr_en}, 32'd0);
            end
            default: begin
                for (int i = 0; i < 8; i++) begin
                    chk("clr_wr_en", {31'd0, rf_wr_en}, 32'd1);
                    chk("clr_addr", {29'd0, rf_wr_addr}, i);
                    chk("clr_data", {16'd0, rf_wr_data}, 32'd0);
                    chk("clr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
                    @(negedge clk);
                end
                chk("clr_done_wr_en", {31'd0, rf_wr_en}, 32'd0);
            end
        endcase
        has = (op == OPR) || ACK_MODE;
        e0 = (op == OPR) ? re0 : ((op == OPX) ? 16'h0000 : wval);
        e1 = (op == OPR) ? re1 : 16'h0000;
        if (has) begin
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_data0", {16'd0, rsp_data0}, {16'd0, e0});
            chk("rsp_data1", {16'd0, rsp_data1}, {16'd0, e1});
            @(negedge clk);
        end
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_rf_zero", {13'd0, rf_wr_addr, rf_rd0_addr, rf_rd1_addr, rf_wr_en},
            32'd0);
        case (op)
            OPW: ref_regs[a] = d;
            OPC: ref_regs[b] = wval;
            OPX: for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
            default: ;
        endcase
    endtask

    initial begin
        logic [15:0] h0, h1;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {rsp_data0, rsp_data1}, 32'd0);
        chk("rst_rf", {1'd0, rf_wr_en, rf_wr_addr, rf_rd0_addr, rf_rd1_addr, rf_wr_data[15:0]},
            32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        do_cmd(OPX, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        vt[0] = '{OPW, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 16'h0000};
        vt[1] = '{OPR, 3'd3, 3'd0, 16'h0000, 16'hBEEF, 16'h0000};
        vt[2] = '{OPW, 3'd1, 3'd0, 16'h1234, 16'h0000, 16'h0000};
        vt[3] = '{OPC, 3'd1, 3'd6, 16'h0000, 16'h0000, 16'h0000};
        vt[4] = '{OPR, 3'd6, 3'd1, 16'h0000, 16'h1234, 16'h1234};
        vt[5] = '{OPW, 3'd2, 3'd0, 16'h00FF, 16'h0000, 16'h0000};
        vt[6] = '{OPR, 3'd2, 3'd3, 16'h0000, 16'h00FF, 16'hBEEF};
        vt[7] = '{OPC, 3'd3, 3'd3, 16'h0000, 16'h0000, 16'h0000};
        vt[8] = '{OPR, 3'd3, 3'd6, 16'h0000, 16'hBEEF, 16'h1234};
        for (int i = 0; i < 9; i++) do_cmd(vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].e0, vt[i].e1);

        // Fill all registers, CLEAR, read everything back
        for (int i = 0; i < 8; i++) do_cmd(OPW, 3'(i), 3'd0, 16'hA000 + 16'(i) + 16'd1, 16'h0, 16'h0);
        do_cmd(OPX, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i += 2) do_cmd(OPR, 3'(i), 3'(i + 1), 16'h0, 16'h0000, 16'h0000);

        // Response back-pressure: data stable, new command held off
        do_cmd(OPW, 3'd5, 3'd0, 16'h5A5A, 16'h0, 16'h0);
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OPR; cmd_addr_a = 3'd5; cmd_addr_b = 3'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        h0 = rsp_data0; h1 = rsp_data1;
        chk("stall_rsp0", {16'd0, h0}, {16'd0, ref_regs[5]});
        chk("stall_rsp1", {16'd0, h1}, {16'd0, ref_regs[2]});
        cmd_valid = 1'b1; cmd_op = OPW; cmd_addr_a = 3'd7; cmd_data = 16'hABCD;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_data", {rsp_data0, rsp_data1}, {h0, h1});
            chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("stall_still_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("stall_released_ready", {31'd0, cmd_ready}, 32'd1);
        chk("stall_released_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("stall_wr_en", {31'd0, rf_wr_en}, 32'd1);
        chk("stall_wr", {13'd0, rf_wr_addr, rf_wr_data}, {13'd0, 3'd7, 16'hABCD});
        ref_regs[7] = 16'hABCD;
        repeat (3) @(negedge clk);

        // Reset in the middle of a CLEAR walk
        for (int i = 0; i < 8; i++) do_cmd(OPW, 3'(i), 3'd0, 16'hC000 + 16'(i) * 16'd3 + 16'd1, 16'h0, 16'h0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OPX;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rclr_addr", {28'd0, rf_wr_en, rf_wr_addr}, {28'd0, 1'b1, 3'(i)});
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("rclr_wr_en_drop", {31'd0, rf_wr_en}, 32'd0);
        chk("rclr_busy", {31'd0, busy}, 32'd0);
        chk("rclr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rclr_post_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) ref_regs[i] = 16'h0000;
        for (int i = 0; i < 4; i++) do_cmd(OPR, 3'(i), 3'(i + 4), 16'h0, ref_regs[i], ref_regs[i + 4]);

        // Random commands against the model
        for (int n = 0; n < 60; n++) begin
            int sel;
            logic [1:0]  op;
            logic [2:0]  a, b;
            logic [15:0] d;
            sel = $urandom_range(0, 12);
            op = (sel < 5) ? OPR : (sel < 9) ? OPW : (sel < 12) ? OPC : OPX;
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            do_cmd(op, a, b, d, ref_regs[a], ref_regs[b]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
